// File: rtl/uart_transceiver_cfg.sv
// Configurable full-duplex UART: 16x oversampled TX and RX with
// majority-vote sampling and framing, parity and break status.
module uart_transceiver_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_e;

  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (baud_div == '0) ? ONE : baud_div;

  st_e                  tx_st_q, tx_st_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_tick_q, tx_tick_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == tx_div_q - ONE);

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_div_d  = tx_div_q;
    tx_cnt_d  = tx_cnt_q;
    tx_tick_d = tx_tick_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    if (tx_st_q == S_IDLE) begin
      tx_d = 1'b1;
      if (tx_start) begin
        tx_st_d   = S_START;
        tx_div_d  = div_eff;
        tx_cnt_d  = '0;
        tx_tick_d = '0;
        tx_bit_d  = '0;
        tx_sh_d   = tx_data;
        tx_par_d  = (^tx_data) ^ PAR_ODD;
        tx_d      = 1'b0;
      end
    end else if (tx_tick) begin
      tx_cnt_d  = '0;
      tx_tick_d = tx_tick_q + 4'd1;
      if (tx_tick_q == 4'd15) begin
        case (tx_st_q)
          S_START: begin
            tx_st_d = S_DATA;
            tx_d    = tx_sh_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == LAST_DATA) begin
              tx_bit_d = '0;
              tx_st_d  = PAR_EN ? S_PAR : S_STOP;
              tx_d     = PAR_EN ? tx_par_q : 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
              tx_sh_d  = tx_sh_q >> 1;
              tx_d     = tx_sh_q[1];
            end
          end
          S_PAR: begin
            tx_st_d = S_STOP;
            tx_d    = 1'b1;
          end
          S_STOP: begin
            if (tx_bit_q == LAST_STOP) begin
              tx_st_d   = S_IDLE;
              tx_done_d = 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
            end
          end
          default: tx_st_d = S_IDLE;
        endcase
      end
    end else begin
      tx_cnt_d = tx_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_st_q   <= S_IDLE;
      tx_div_q  <= ONE;
      tx_cnt_q  <= '0;
      tx_tick_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_div_q  <= tx_div_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_tick_q <= tx_tick_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_st_q != S_IDLE);
  assign tx_done = tx_done_q;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  st_e                  rx_st_q, rx_st_d;
  logic [DIV_W-1:0]     rx_div_q, rx_div_d;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]           rx_vote_q, rx_vote_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_fe_q, rx_fe_d;
  logic                 rx_pe_q, rx_pe_d;
  logic                 rx_brk_q, rx_brk_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_tick, maj;

  assign rx_tick = (rx_cnt_q == rx_div_q - ONE);
  assign maj = (rx_vote_q[0] & rx_vote_q[1]) |
               (rx_vote_q[0] & rx_s2_q) |
               (rx_vote_q[1] & rx_s2_q);

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_div_d  = rx_div_q;
    rx_cnt_d  = rx_cnt_q;
    rx_tick_d = rx_tick_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_vote_d = rx_vote_q;
    rx_pbit_d = rx_pbit_q;
    rx_data_d = rx_data_q;
    rx_fe_d   = rx_fe_q;
    rx_pe_d   = rx_pe_q;
    rx_brk_d  = rx_brk_q;
    rx_done_d = 1'b0;
    if (rx_st_q == S_IDLE) begin
      // Only a high-to-low transition starts a frame, so a stuck-low
      // line after a break cannot retrigger.
      if (rx_prev_q && !rx_s2_q) begin
        rx_st_d   = S_START;
        rx_div_d  = div_eff;
        rx_cnt_d  = '0;
        rx_tick_d = '0;
        rx_bit_d  = '0;
      end
    end else if (rx_tick) begin
      rx_cnt_d  = '0;
      rx_tick_d = rx_tick_q + 4'd1;
      if (rx_tick_q == 4'd7) rx_vote_d[0] = rx_s2_q;
      if (rx_tick_q == 4'd8) rx_vote_d[1] = rx_s2_q;
      if (rx_tick_q == 4'd9) begin
        case (rx_st_q)
          S_START: if (maj) rx_st_d = S_IDLE;
          S_DATA:  rx_sh_d = {maj, rx_sh_q[DATA_BITS-1:1]};
          S_PAR:   rx_pbit_d = maj;
          S_STOP: begin
            rx_st_d   = S_IDLE;
            rx_done_d = 1'b1;
            rx_data_d = rx_sh_q;
            rx_fe_d   = !maj;
            rx_pe_d   = PAR_EN && ((^rx_sh_q) ^ rx_pbit_q ^ PAR_ODD);
            rx_brk_d  = !maj && (rx_sh_q == '0) &&
                        !(PAR_EN && rx_pbit_q);
          end
          default: ;
        endcase
      end
      if (rx_tick_q == 4'd15) begin
        case (rx_st_q)
          S_START: rx_st_d = S_DATA;
          S_DATA: begin
            if (rx_bit_q == LAST_DATA) begin
              rx_bit_d = '0;
              rx_st_d  = PAR_EN ? S_PAR : S_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
          S_PAR:   rx_st_d = S_STOP;
          default: ;
        endcase
      end
    end else begin
      rx_cnt_d = rx_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q   <= 1'b0;
      rx_s2_q   <= 1'b0;
      rx_prev_q <= 1'b0;
      rx_st_q   <= S_IDLE;
      rx_div_q  <= ONE;
      rx_cnt_q  <= '0;
      rx_tick_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_vote_q <= '0;
      rx_pbit_q <= 1'b0;
      rx_data_q <= '0;
      rx_fe_q   <= 1'b0;
      rx_pe_q   <= 1'b0;
      rx_brk_q  <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_div_q  <= rx_div_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_tick_q <= rx_tick_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_vote_q <= rx_vote_d;
      rx_pbit_q <= rx_pbit_d;
      rx_data_q <= rx_data_d;
      rx_fe_q   <= rx_fe_d;
      rx_pe_q   <= rx_pe_d;
      rx_brk_q  <= rx_brk_d;
      rx_done_q <= rx_done_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign rx_busy       = (rx_st_q != S_IDLE);
  assign rx_frame_err  = rx_fe_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_break      = rx_brk_q;
endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Directed bench for uart_transceiver_cfg: 8N1 TX, 7E2 TX with
// back-to-back frames, and 8O1 RX loopback, errors and false start.
module tb_uart_transceiver_cfg;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [15:0] a_div;
  logic        a_start, a_tx, a_busy, a_done, a_rx;
  logic [7:0]  a_data, a_rxd;
  logic        a_rdone, a_rbusy, a_fe, a_pe, a_brk;

  logic [15:0] b_div;
  logic        b_start, b_tx, b_busy, b_done;
  logic [6:0]  b_data, b_rxd;
  logic        b_rdone, b_rbusy, b_fe, b_pe, b_brk;

  logic [15:0] c_div;
  logic        c_start, c_tx, c_busy, c_done;
  logic        c_loop, c_rxdrv, c_rx;
  logic [7:0]  c_data, c_rxd;
  logic        c_rdone, c_rbusy, c_fe, c_pe, c_brk;

  assign c_rx = c_loop ? c_tx : c_rxdrv;

  uart_transceiver_cfg #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)
  ) u_a (
    .clk(clk), .rstn(rstn), .baud_div(a_div),
    .tx_start(a_start), .tx_data(a_data), .tx(a_tx),
    .tx_busy(a_busy), .tx_done(a_done), .rx(a_rx),
    .rx_data(a_rxd), .rx_done(a_rdone), .rx_busy(a_rbusy),
    .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_break(a_brk)
  );

  uart_transceiver_cfg #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV_W(16)
  ) u_b (
    .clk(clk), .rstn(rstn), .baud_div(b_div),
    .tx_start(b_start), .tx_data(b_data), .tx(b_tx),
    .tx_busy(b_busy), .tx_done(b_done), .rx(b_tx),
    .rx_data(b_rxd), .rx_done(b_rdone), .rx_busy(b_rbusy),
    .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_break(b_brk)
  );

  uart_transceiver_cfg #(
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16)
  ) u_c (
    .clk(clk), .rstn(rstn), .baud_div(c_div),
    .tx_start(c_start), .tx_data(c_data), .tx(c_tx),
    .tx_busy(c_busy), .tx_done(c_done), .rx(c_rx),
    .rx_data(c_rxd), .rx_done(c_rdone), .rx_busy(c_rbusy),
    .rx_frame_err(c_fe), .rx_parity_err(c_pe), .rx_break(c_brk)
  );

  int   c_done_cnt = 0;
  int   c_rise_cnt = 0;
  logic c_rbusy_prev = 1'b0;

  always @(negedge clk) begin
    if (c_rdone) c_done_cnt <= c_done_cnt + 1;
    if (c_rbusy && !c_rbusy_prev) c_rise_cnt <= c_rise_cnt + 1;
    c_rbusy_prev <= c_rbusy;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_done, a_rxd, a_rdone, a_rbusy,
         a_fe, a_pe, a_brk} !== {1'b1, 15'h0}) begin
      bad++;
      $display("FAIL reset_a got %b want 1 and zeros",
               {a_tx, a_busy, a_done, a_rdone, a_rbusy});
    end
    total++;
    if ({c_tx, c_busy, c_done, c_rxd, c_rdone, c_rbusy,
         c_fe, c_pe, c_brk} !== {1'b1, 15'h0}) begin
      bad++;
      $display("FAIL reset_c got %b want 1 and zeros",
               {c_tx, c_busy, c_done, c_rdone, c_rbusy});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    a_div = 16'd4; a_data = 8'h00; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if ({a_tx, a_busy} !== 2'b01) begin
      bad++;
      $display("FAIL midframe got %b want 01", {a_tx, a_busy});
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({a_tx, a_busy, a_done} !== 3'b100) begin
      bad++;
      $display("FAIL async_rst got %b want 100",
               {a_tx, a_busy, a_done});
    end
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_done, a_rbusy} !== 4'b1000) begin
      bad++;
      $display("FAIL post_rst got %b want 1000",
               {a_tx, a_busy, a_done, a_rbusy});
    end
  endtask

  task automatic test_tx_8n1();
    logic [15:0] dv [3] = '{16'd4, 16'd4, 16'd0};
    logic [7:0]  dd [3] = '{8'h55, 8'hA5, 8'h3C};
    for (int v = 0; v < 3; v++) begin
      int L;
      logic [9:0] fr;
      L  = 16 * ((dv[v] == 16'd0) ? 1 : int'(dv[v]));
      fr = {1'b1, dd[v], 1'b0};
      @(negedge clk);
      total++;
      if (a_busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_busy v=%0d got %b want 0", v, a_busy);
      end
      a_div = dv[v]; a_data = dd[v]; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_div = 16'd7; a_data = ~dd[v];
      total++;
      if ({a_tx, a_busy} !== 2'b01) begin
        bad++;
        $display("FAIL accept v=%0d got %b want 01",
                 v, {a_tx, a_busy});
      end
      repeat (L / 2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        if (k == 4) a_start = 1'b1;
        if (k == 5) a_start = 1'b0;
        total++;
        if (a_tx !== fr[k]) begin
          bad++;
          $display("FAIL txbit v=%0d k=%0d got %b want %b",
                   v, k, a_tx, fr[k]);
        end
        if (k < 9) repeat (L) @(negedge clk);
      end
      repeat (L / 2 - 1) @(negedge clk);
      total++;
      if ({a_busy, a_done} !== 2'b10) begin
        bad++;
        $display("FAIL pre_done v=%0d got %b want 10",
                 v, {a_busy, a_done});
      end
      @(negedge clk);
      total++;
      if ({a_busy, a_done, a_tx} !== 3'b011) begin
        bad++;
        $display("FAIL done v=%0d got %b want 011",
                 v, {a_busy, a_done, a_tx});
      end
      @(negedge clk);
      total++;
      if ({a_busy, a_done} !== 2'b00) begin
        bad++;
        $display("FAIL post_done v=%0d got %b want 00",
                 v, {a_busy, a_done});
      end
    end
  endtask

  task automatic test_tx_7e2_b2b();
    logic [10:0] fr [2];
    fr[0] = {2'b11, 1'b0, 7'h41, 1'b0};
    fr[1] = {2'b11, 1'b1, 7'h7F, 1'b0};
    @(negedge clk);
    b_div = 16'd4; b_data = 7'h41; b_start = 1'b1;
    @(negedge clk);
    b_data = 7'h7F;
    for (int f = 0; f < 2; f++) begin
      total++;
      if ({b_tx, b_busy} !== 2'b01) begin
        bad++;
        $display("FAIL b_accept f=%0d got %b want 01",
                 f, {b_tx, b_busy});
      end
      if (f == 1) b_start = 1'b0;
      repeat (32) @(negedge clk);
      for (int k = 0; k < 11; k++) begin
        total++;
        if (b_tx !== fr[f][k]) begin
          bad++;
          $display("FAIL b_bit f=%0d k=%0d got %b want %b",
                   f, k, b_tx, fr[f][k]);
        end
        if (k < 10) repeat (64) @(negedge clk);
      end
      repeat (31) @(negedge clk);
      total++;
      if ({b_busy, b_done} !== 2'b10) begin
        bad++;
        $display("FAIL b_pre_done f=%0d got %b want 10",
                 f, {b_busy, b_done});
      end
      @(negedge clk);
      total++;
      if ({b_busy, b_done, b_tx} !== 3'b011) begin
        bad++;
        $display("FAIL b_done f=%0d got %b want 011",
                 f, {b_busy, b_done, b_tx});
      end
      @(negedge clk);
    end
    total++;
    if ({b_busy, b_done, b_tx} !== 3'b001) begin
      bad++;
      $display("FAIL b_idle got %b want 001", {b_busy, b_done, b_tx});
    end
    total++;
    if ({b_rxd, b_fe, b_pe, b_brk} !== {7'h7F, 3'b000}) begin
      bad++;
      $display("FAIL b_loop got %h/%b want 7f/000",
               b_rxd, {b_fe, b_pe, b_brk});
    end
  endtask

  task automatic test_rx_loopback();
    logic [7:0] dd [3] = '{8'h00, 8'hFF, 8'h3C};
    c_loop = 1'b1;
    for (int v = 0; v < 3; v++) begin
      int n0, r0, t;
      n0 = c_done_cnt; r0 = c_rise_cnt; t = 0;
      @(negedge clk);
      c_div = 16'd4; c_data = dd[v]; c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      while (c_busy && t < 3000) begin
        @(negedge clk);
        t++;
      end
      total++;
      if (t >= 3000) begin
        bad++;
        $display("FAIL loop_timeout v=%0d got busy want idle", v);
      end
      repeat (2) @(negedge clk);
      total++;
      if ((c_done_cnt - n0) != 1 || (c_rise_cnt - r0) != 1) begin
        bad++;
        $display("FAIL loop_pulse v=%0d got %0d/%0d want 1/1",
                 v, c_done_cnt - n0, c_rise_cnt - r0);
      end
      total++;
      if ({c_rxd, c_fe, c_pe, c_brk, c_rbusy} !==
          {dd[v], 4'b0000}) begin
        bad++;
        $display("FAIL loop_data v=%0d got %h/%b want %h/0000",
                 v, c_rxd, {c_fe, c_pe, c_brk, c_rbusy}, dd[v]);
      end
    end
    c_loop = 1'b0;
  endtask

  task automatic drive_c(input logic [10:0] bits, input int gbit);
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 64; c++) begin
        c_rxdrv = (k == gbit && c >= 34 && c < 38) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    c_rxdrv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic test_rx_glitch();
    int n0;
    n0 = c_done_cnt;
    c_div = 16'd4;
    drive_c({1'b1, 1'b1, 8'h3C, 1'b0}, 4);
    total++;
    if ((c_done_cnt - n0) != 1 ||
        {c_rxd, c_fe, c_pe, c_brk} !== {8'h3C, 3'b000}) begin
      bad++;
      $display("FAIL glitch got n=%0d %h/%b want n=1 3c/000",
               c_done_cnt - n0, c_rxd, {c_fe, c_pe, c_brk});
    end
  endtask

  task automatic test_rx_errors();
    int n0;
    n0 = c_done_cnt;
    drive_c({1'b0, 1'b1, 8'h55, 1'b0}, -1);
    total++;
    if ((c_done_cnt - n0) != 1 ||
        {c_rxd, c_fe, c_pe, c_brk} !== {8'h55, 3'b100}) begin
      bad++;
      $display("FAIL frame_err got n=%0d %h/%b want n=1 55/100",
               c_done_cnt - n0, c_rxd, {c_fe, c_pe, c_brk});
    end
    n0 = c_done_cnt;
    drive_c({1'b1, 1'b0, 8'h55, 1'b0}, -1);
    total++;
    if ((c_done_cnt - n0) != 1 ||
        {c_rxd, c_fe, c_pe, c_brk} !== {8'h55, 3'b010}) begin
      bad++;
      $display("FAIL parity_err got n=%0d %h/%b want n=1 55/010",
               c_done_cnt - n0, c_rxd, {c_fe, c_pe, c_brk});
    end
    n0 = c_done_cnt;
    c_rxdrv = 1'b0;
    repeat (12 * 64) @(negedge clk);
    c_rxdrv = 1'b1;
    repeat (128) @(negedge clk);
    total++;
    if ((c_done_cnt - n0) != 1 ||
        {c_rxd, c_fe, c_pe, c_brk} !== {8'h00, 3'b111}) begin
      bad++;
      $display("FAIL break got n=%0d %h/%b want n=1 00/111",
               c_done_cnt - n0, c_rxd, {c_fe, c_pe, c_brk});
    end
  endtask

  task automatic test_false_start();
    int n0, r0;
    n0 = c_done_cnt; r0 = c_rise_cnt;
    c_rxdrv = 1'b0;
    repeat (20) @(negedge clk);
    c_rxdrv = 1'b1;
    repeat (128) @(negedge clk);
    total++;
    if ((c_done_cnt - n0) != 0 || (c_rise_cnt - r0) != 1 ||
        c_rbusy !== 1'b0) begin
      bad++;
      $display("FAIL false_start got n=%0d r=%0d b=%b want 0 1 0",
               c_done_cnt - n0, c_rise_cnt - r0, c_rbusy);
    end
    n0 = c_done_cnt;
    drive_c({1'b1, 1'b1, 8'hC3, 1'b0}, -1);
    total++;
    if ((c_done_cnt - n0) != 1 ||
        {c_rxd, c_fe, c_pe, c_brk} !== {8'hC3, 3'b000}) begin
      bad++;
      $display("FAIL after_false got n=%0d %h/%b want n=1 c3/000",
               c_done_cnt - n0, c_rxd, {c_fe, c_pe, c_brk});
    end
  endtask

  initial begin
    a_div = 16'd4; a_start = 1'b0; a_data = '0; a_rx = 1'b1;
    b_div = 16'd4; b_start = 1'b0; b_data = '0;
    c_div = 16'd4; c_start = 1'b0; c_data = '0;
    c_loop = 1'b0; c_rxdrv = 1'b1;
    test_reset();
    test_tx_8n1();
    test_tx_7e2_b2b();
    test_rx_loopback();
    test_rx_glitch();
    test_rx_errors();
    test_false_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
